// File: rtl/fp_post_norm.sv
// fp_post_norm: renormalises the raw add/sub mantissa sum, adjusts the exponent and packs the result.
// Two register stages under one global stall; define FP_NORM_DENORM_EN to emit subnormals on underflow.
module fp_post_norm #(
   parameter int ex_width  = 8,
   parameter int man_width = 23
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          sign,
   input  logic [ex_width-1:0]           max_exp,
   input  logic [man_width+1:0]          mant_sum,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ex_width+man_width:0]   result,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int lzc_w = $clog2(man_width + 2);
   localparam int xw    = ex_width + 1;
   localparam logic [xw-1:0] exp_all_ones = {1'b0, {ex_width{1'b1}}};

   logic en;

   logic                   s1_valid_q, s1_valid_d;
   logic                   s1_sign_q,  s1_sign_d;
   logic [ex_width-1:0]    s1_exp_q,   s1_exp_d;
   logic [man_width+1:0]   s1_mant_q,  s1_mant_d;
   logic [lzc_w-1:0]       s1_lzc_q,   s1_lzc_d;

   logic                          out_valid_q, out_valid_d;
   logic [ex_width+man_width:0]   result_q,    result_d;
   logic                          overflow_q,  overflow_d;
   logic                          underflow_q, underflow_d;

   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   // Leading zeros of {hidden, fraction}; the carry bit is handled separately in stage 2.
   logic [lzc_w-1:0] lzc;
   always_comb begin
      lzc = lzc_w'(man_width + 1);
      for (int i = 0; i <= man_width; i++) begin
         if (mant_sum[i]) lzc = lzc_w'(man_width - i);
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_exp_d   = s1_exp_q;
      s1_mant_d  = s1_mant_q;
      s1_lzc_d   = s1_lzc_q;
      if (en) begin
         s1_valid_d = in_valid;
         s1_sign_d  = sign;
         s1_exp_d   = max_exp;
         s1_mant_d  = mant_sum;
         s1_lzc_d   = lzc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_mant_q  <= '0;
         s1_lzc_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sign_q  <= s1_sign_d;
         s1_exp_q   <= s1_exp_d;
         s1_mant_q  <= s1_mant_d;
         s1_lzc_q   <= s1_lzc_d;
      end
   end

   logic [xw-1:0]          exp_x, lzc_x, exp_inc;
   logic [man_width-1:0]   norm_frac;
   logic [ex_width-1:0]    norm_exp;
   logic                   sign_n, ovf_n, unf_n;
   logic [ex_width-1:0]    exp_n;
   logic [man_width-1:0]   frac_n;
`ifdef FP_NORM_DENORM_EN
   logic [ex_width-1:0]    sub_amt;
   logic [man_width-1:0]   sub_frac;
`endif

   // Exponent math is one bit wider so max_exp+1 and max_exp-lzc never wrap.
   always_comb begin
      exp_x     = {1'b0, s1_exp_q};
      lzc_x     = xw'(s1_lzc_q);
      exp_inc   = exp_x + xw'(1);
      norm_exp  = ex_width'(exp_x - lzc_x);
      norm_frac = man_width'(s1_mant_q << s1_lzc_q);
`ifdef FP_NORM_DENORM_EN
      sub_amt   = (s1_exp_q == '0) ? '0 : s1_exp_q - ex_width'(1);
      sub_frac  = man_width'(s1_mant_q << sub_amt);
`endif
      sign_n = s1_sign_q;
      exp_n  = '0;
      frac_n = '0;
      ovf_n  = 1'b0;
      unf_n  = 1'b0;
      if (s1_mant_q == '0) begin
         sign_n = 1'b0;
      end else if (s1_mant_q[man_width+1]) begin
         if (exp_inc >= exp_all_ones) begin
            exp_n = '1;
            ovf_n = 1'b1;
         end else begin
            exp_n  = exp_inc[ex_width-1:0];
            frac_n = s1_mant_q[man_width:1];
         end
      end else if (lzc_x < exp_x) begin
         exp_n  = norm_exp;
         frac_n = norm_frac;
      end else begin
`ifdef FP_NORM_DENORM_EN
         frac_n = sub_frac;
         unf_n  = (sub_frac == '0);
`else
         unf_n  = 1'b1;
`endif
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (en) begin
         out_valid_d = s1_valid_q;
         result_d    = {sign_n, exp_n, frac_n};
         overflow_d  = ovf_n && s1_valid_q;
         underflow_d = unf_n && s1_valid_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_fp_post_norm.sv
// Scoreboard bench for fp_post_norm: a driver issues beats, a monitor checks each delivered result
// against an integer-arithmetic reference model queued at acceptance time.
module tb_fp_post_norm;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        sign;
   logic [7:0]  max_exp;
   logic [24:0] mant_sum;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;

   fp_post_norm #(.ex_width(8), .man_width(23)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sign      (sign),
      .max_exp   (max_exp),
      .mant_sum  (mant_sum),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;
   int bp_mode  = 0;     // 0: always ready, 1: random, 2: never ready
   int stall_cycles = 0;
   logic saw_stall;
   logic [33:0] exp_q[$];
   logic        prev_hold;
   logic [33:0] prev_out;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference: locate the leading one, then scale by powers of two; returns {result, overflow, underflow}.
   function automatic logic [33:0] model(input logic s, input logic [7:0] e, input logic [24:0] m);
      int p, lz, ex, sh;
      longint v;
      logic [22:0] f;
      p = -1;
      for (int i = 0; i < 25; i++) if (m[i]) p = i;
      if (p < 0) return 34'h0;
      if (p == 24) begin
         ex = int'(e) + 1;
         if (ex >= 255) return {s, 8'hFF, 23'h0, 1'b1, 1'b0};
         v = longint'(m) / 2;
         f = v[22:0];
         return {s, ex[7:0], f, 2'b00};
      end
      lz = 23 - p;
      if (lz < int'(e)) begin
         ex = int'(e) - lz;
         v  = longint'(m) * (longint'(1) << lz);
         f  = v[22:0];
         return {s, ex[7:0], f, 2'b00};
      end
`ifdef FP_NORM_DENORM_EN
      sh = (e > 0) ? int'(e) - 1 : 0;
      v  = longint'(m) * (longint'(1) << sh);
      f  = v[22:0];
      return {s, 8'h00, f, 1'b0, (f == 23'h0)};
`else
      sh = 0;
      return {s, 8'h00, 23'h0, 1'b0, 1'b1};
`endif
   endfunction

   // Monitor: sample mid-cycle, pop on output handshake, push on input handshake.
   initial begin
      logic [33:0] e;
      prev_hold = 1'b0;
      prev_out  = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (prev_hold) begin
               chk("hold_valid", 64'(out_valid), 64'd1);
               chk("hold_data", 64'({result, overflow, underflow}), 64'(prev_out));
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {result, overflow, underflow};
            if (out_valid && out_ready) begin
               n_out++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", 64'(exp_q.size()), 64'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("result", 64'(result), 64'(e[33:2]));
                  chk("flags", 64'({overflow, underflow}), 64'(e[1:0]));
               end
            end
            if (in_valid && in_ready) exp_q.push_back(model(sign, max_exp, mant_sum));
         end else begin
            prev_hold = 1'b0;
         end
      end
   end

   task automatic set_ready();
      if (stall_cycles > 0) begin
         out_ready = 1'b0;
         stall_cycles--;
      end else if (bp_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (bp_mode != 2);
   endtask

   task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
      int n;
      n = 0;
      @(posedge clk); #1;
      sign = s; max_exp = e; mant_sum = m; in_valid = 1'b1;
      set_ready();
      @(negedge clk);
      while (!in_ready && n < 100) begin
         saw_stall = 1'b1;
         @(posedge clk); #1;
         set_ready();
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("send_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         set_ready();
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      bp_mode = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic directed(input string name, input logic s, input logic [7:0] e, input logic [24:0] m,
                           input logic [31:0] exp_res, input logic exp_ov, input logic exp_un);
      int lat;
      drain();
      send(s, e, m);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 10);
      chk({name, "_latency"}, 64'(lat), 64'd2);
      chk({name, "_result"}, 64'(result), 64'(exp_res));
      chk({name, "_flags"}, 64'({overflow, underflow}), 64'({exp_ov, exp_un}));
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_before;
      logic [31:0] r;
      logic [7:0]  e;
      logic [24:0] m;
      int k;

      rst_n = 1'b0; in_valid = 1'b0; sign = 1'b0; max_exp = '0; mant_sum = '0; out_ready = 1'b1;
      saw_stall = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_result", 64'(result), 64'd0);
      chk("reset_flags", 64'({overflow, underflow}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_in_ready", 64'(in_ready), 64'd1);
      chk("post_reset_out_valid", 64'(out_valid), 64'd0);

      directed("pass", 1'b0, 8'h80, 25'h0800000, 32'h40000000, 1'b0, 1'b0);
      directed("carry", 1'b0, 8'h80, 25'h1000001, 32'h40800000, 1'b0, 1'b0);
      directed("cancel", 1'b0, 8'h80, 25'h0000100, 32'h38800000, 1'b0, 1'b0);
      directed("ovf", 1'b1, 8'hFE, 25'h1000000, 32'hFF800000, 1'b1, 1'b0);
      directed("zero", 1'b1, 8'h10, 25'h0000000, 32'h00000000, 1'b0, 1'b0);
      directed("min_norm", 1'b0, 8'h01, 25'h0800000, 32'h00800000, 1'b0, 1'b0);
`ifdef FP_NORM_DENORM_EN
      directed("unf", 1'b0, 8'h03, 25'h0000100, 32'h00000400, 1'b0, 1'b0);
      directed("unf_exp0", 1'b1, 8'h00, 25'h0400000, 32'h80400000, 1'b0, 1'b0);
`else
      directed("unf", 1'b0, 8'h03, 25'h0000100, 32'h00000000, 1'b0, 1'b1);
      directed("unf_exp0", 1'b1, 8'h00, 25'h0400000, 32'h80000000, 1'b0, 1'b1);
`endif

      // Backpressure: four back-to-back beats while downstream stalls.
      drain();
      n_before = n_out;
      saw_stall = 1'b0;
      bp_mode = 0;
      stall_cycles = 3;
      send(1'b0, 8'h80, 25'h0800000);
      send(1'b1, 8'h7F, 25'h1800000);
      send(1'b0, 8'h90, 25'h0000F00);
      send(1'b1, 8'h02, 25'h0000001);
      drain();
      chk("bp_in_ready_low", 64'(saw_stall), 64'd1);
      chk("bp_count", 64'(n_out - n_before), 64'd4);

      // Randomised traffic with random backpressure and bubbles.
      bp_mode = 1;
      for (int i = 0; i < 300; i++) begin
         r = $urandom;
         case ($urandom_range(0, 3))
            0:       e = 8'($urandom_range(0, 30));
            1:       e = 8'($urandom_range(240, 254));
            default: e = 8'($urandom_range(0, 254));
         endcase
         k = $urandom_range(0, 25);
         m = 25'(r >> (32 - k));
         send(1'($urandom_range(0, 1)), e, m);
         if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end
      drain();

      // Reset with beats in flight.
      bp_mode = 2;
      send(1'b0, 8'h80, 25'h0800000);
      send(1'b1, 8'h81, 25'h0C00000);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("pre_reset_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", 64'(out_valid), 64'd0);
      chk("midreset_result", 64'(result), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bp_mode = 0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("after_reset_valid1", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk("after_reset_valid2", 64'(out_valid), 64'd0);
      directed("post_rst", 1'b0, 8'h80, 25'h0800000, 32'h40000000, 1'b0, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
